// File: rtl/crc32_pkg.sv
// crc32_pkg
// Shared constants and types for the streaming CRC-32 (IEEE 802.3) engine.
//   CRC32_POLY_REFL : reflected generator polynomial (LSB-first processing)
//   CRC32_RESIDUE   : raw register value left after a frame plus its own FCS
//   CRC32_INIT_DEF  : default register preset
//   CRC32_XOR_DEF   : default final XOR
//   crc_state_t     : two-state frame controller encoding
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;
  localparam logic [31:0] CRC32_INIT_DEF  = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOR_DEF   = 32'hFFFFFFFF;

  // ST_ACC: accumulating beats; ST_HOLD: presenting a finished result.
  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } crc_state_t;

endpackage

// File: rtl/crc32_byte_step.sv
// crc32_byte_step
// Purely combinational: advances a raw CRC-32 register by one byte,
// consuming the byte LSB-first (eight bit-serial LFSR steps unrolled).
//   r         in  32  current raw register
//   data_byte in   8  byte to absorb
//   r_next    out 32  register after absorbing data_byte
module crc32_byte_step
  import crc32_pkg::*;
(
  input  logic [31:0] r,
  input  logic [7:0]  data_byte,
  output logic [31:0] r_next
);

  always_comb begin
    // NOTE: blocking assignments are deliberate in combinational logic; each
    // loop iteration must see the value produced by the previous bit step.
    r_next = r;
    for (int i = 0; i < 8; i++) begin
      if (r_next[0] ^ data_byte[i]) begin
        r_next = (r_next >> 1) ^ CRC32_POLY_REFL;
      end else begin
        r_next = r_next >> 1;
      end
    end
  end

endmodule

// File: rtl/crc32_stream.sv
// crc32_stream
// Streaming CRC-32 engine, 1/2/4 bytes per beat, valid/ready on both sides.
// Generate mode presents the FCS; check mode also flags a good residue.
//   clk, rst_n          clock, asynchronous active-low reset
//   clr                 synchronous abort back to accumulate with r = INIT
//   in_valid/in_ready   input beat handshake
//   in_data             lane 0 = [7:0] is absorbed first
//   in_keep             byte enables, honoured only on the in_last beat
//   in_last             final beat of the frame
//   out_valid/out_ready result handshake
//   out_crc             final register XOR XOR_OUT (transmit byte 0 = [7:0])
//   out_ok              CHECK=1: frame+FCS left the residue; CHECK=0: 0
module crc32_stream
  import crc32_pkg::*;
#(
  parameter int          DATA_W  = 8,
  parameter logic [31:0] INIT    = CRC32_INIT_DEF,
  parameter logic [31:0] XOR_OUT = CRC32_XOR_DEF,
  parameter bit          CHECK   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [DATA_W/8-1:0]   in_keep,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_crc,
  output logic                  out_ok
);

  localparam int NB = DATA_W / 8;
  localparam int KW = $clog2(NB + 1);

  crc_state_t        state, state_nxt;
  logic [31:0]       r;
  logic [NB:0][31:0] chain;     // chain[j] = r advanced by j bytes
  logic [KW-1:0]     keep_len;  // bytes enabled on the last beat
  logic [31:0]       r_final;
  logic              beat_acc;

  // Byte-step chain, lane 0 first.
  assign chain[0] = r;
  for (genvar j = 0; j < NB; j++) begin : g_lane
    crc32_byte_step u_step (
      .r         (chain[j]),
      .data_byte (in_data[8*j +: 8]),
      .r_next    (chain[j+1])
    );
  end

  // Length of the run of ones from lane 0; the lowest zero lane wins, so
  // non-contiguous enables truncate at the first gap.
  always_comb begin
    keep_len = KW'(NB);
    for (int i = NB - 1; i >= 0; i--) begin
      if (!in_keep[i]) keep_len = KW'(i);
    end
  end

  assign r_final  = chain[keep_len];
  assign beat_acc = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ACC;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaulting state_nxt first keeps every path assigned, so no latch.
    state_nxt = state;
    if (clr) begin
      state_nxt = ST_ACC;
    end else begin
      case (state)
        ST_ACC:  if (beat_acc && in_last) state_nxt = ST_HOLD;
        ST_HOLD: if (out_ready)           state_nxt = ST_ACC;
        default: state_nxt = ST_ACC;
      endcase
    end
  end

  // Outputs decoded from the registered state only: no path from out_ready.
  always_comb begin
    in_ready  = (state == ST_ACC);
    out_valid = (state == ST_HOLD);
  end

  // CRC register and captured result.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values. r presets to INIT, not zero.
    if (!rst_n) begin
      r       <= INIT;
      out_crc <= '0;
      out_ok  <= 1'b0;
    end else if (clr) begin
      r       <= INIT;
      out_crc <= '0;
      out_ok  <= 1'b0;
    end else if (beat_acc) begin
      if (in_last) begin
        r       <= INIT;
        out_crc <= r_final ^ XOR_OUT;
        out_ok  <= CHECK && (r_final == CRC32_RESIDUE);
      end else begin
        r <= chain[NB];
      end
    end
  end

endmodule

// File: tb/tb_crc32_stream.sv
// tb_crc32_stream
// Three instances share clk/rst_n/clr: 32-bit generate, 16-bit generate and
// 8-bit check mode. Expected values come from fixed vectors and a
// table-driven byte-at-a-time CRC-32 reference.
module tb_crc32_stream;
  import crc32_pkg::*;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, clr;

  logic        v8, rdy8, l8, ov8, ordy8, ok8;
  logic [7:0]  d8;
  logic [0:0]  k8;
  logic [31:0] crc8;

  logic        v16, rdy16, l16, ov16, ordy16, ok16;
  logic [15:0] d16;
  logic [1:0]  k16;
  logic [31:0] crc16;

  logic        v32, rdy32, l32, ov32, ordy32, ok32;
  logic [31:0] d32;
  logic [3:0]  k32;
  logic [31:0] crc32;

  crc32_stream #(.DATA_W(8), .CHECK(1'b1)) u8c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(v8), .in_ready(rdy8),
    .in_data(d8), .in_keep(k8), .in_last(l8), .out_valid(ov8),
    .out_ready(ordy8), .out_crc(crc8), .out_ok(ok8));

  crc32_stream #(.DATA_W(16)) u16 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(v16), .in_ready(rdy16),
    .in_data(d16), .in_keep(k16), .in_last(l16), .out_valid(ov16),
    .out_ready(ordy16), .out_crc(crc16), .out_ok(ok16));

  crc32_stream #(.DATA_W(32)) u32 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(v32), .in_ready(rdy32),
    .in_data(d32), .in_keep(k32), .in_last(l32), .out_valid(ov32),
    .out_ready(ordy32), .out_crc(crc32), .out_ok(ok32));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference model: standard 256-entry reflected CRC-32 table.
  logic [31:0] crc_tab [256];

  task automatic build_tab();
    logic [31:0] c;
    for (int n = 0; n < 256; n++) begin
      c = 32'(n);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[n] = c;
    end
  endtask

  function automatic logic [31:0] ref_fcs(input bq_t q);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (q[i]) c = crc_tab[c[7:0] ^ q[i]] ^ (c >> 8);
    return c ^ 32'hFFFFFFFF;
  endfunction

  // ---------------- beat drivers ----------------
  task automatic beat8(input logic [7:0] d, input logic k, input logic l);
    logic acc = 1'b0;
    int n = 0;
    d8 = d; k8 = k; l8 = l; v8 = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk); acc = rdy8;
      @(posedge clk); #1; n++;
    end
    v8 = 1'b0;
    if (!acc) check("beat8_accept", 32'(acc), 32'd1);
  endtask

  task automatic beat16(input logic [15:0] d, input logic [1:0] k, input logic l);
    logic acc = 1'b0;
    int n = 0;
    d16 = d; k16 = k; l16 = l; v16 = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk); acc = rdy16;
      @(posedge clk); #1; n++;
    end
    v16 = 1'b0;
    if (!acc) check("beat16_accept", 32'(acc), 32'd1);
  endtask

  task automatic beat32(input logic [31:0] d, input logic [3:0] k, input logic l);
    logic acc = 1'b0;
    int n = 0;
    d32 = d; k32 = k; l32 = l; v32 = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk); acc = rdy32;
      @(posedge clk); #1; n++;
    end
    v32 = 1'b0;
    if (!acc) check("beat32_accept", 32'(acc), 32'd1);
  endtask

  // ---------------- frame drivers ----------------
  task automatic frame8(input bq_t q, input logic [31:0] exp, input logic exp_ok, input string name);
    if (q.size() == 0) beat8(8'($urandom), 1'b0, 1'b1);
    else foreach (q[i]) beat8(q[i], (i == q.size() - 1) ? 1'b1 : 1'($urandom), i == q.size() - 1);
    check({name, "_valid"}, 32'(ov8), 32'd1);
    check({name, "_crc"}, crc8, exp);
    check({name, "_ok"}, 32'(ok8), 32'(exp_ok));
    @(posedge clk); #1;
    check({name, "_release"}, 32'(ov8), 32'd0);
  endtask

  // junk: random idle gaps, random keep on non-last beats, and stray enable
  // bits above the first zero on the last beat. hold: cycles out_ready low.
  task automatic frame32(input bq_t q, input logic [31:0] exp, input bit junk,
                         input int hold, input string name);
    int n, nbeats, rem;
    logic [31:0] d;
    logic [3:0]  k;
    n = q.size();
    nbeats = (n == 0) ? 1 : (n + 3) / 4;
    ordy32 = (hold == 0);
    for (int b = 0; b < nbeats; b++) begin
      if (junk) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      d = $urandom;
      for (int j = 0; j < 4; j++) if (4 * b + j < n) d[8*j +: 8] = q[4 * b + j];
      if (b == nbeats - 1) begin
        rem = n - 4 * b;
        k = 4'((1 << rem) - 1);
        if (junk && rem < 4) k = k | (4'($urandom) & ~4'((2 << rem) - 1));
        beat32(d, k, 1'b1);
      end else begin
        beat32(d, junk ? 4'($urandom) : 4'hF, 1'b0);
      end
    end
    check({name, "_valid"}, 32'(ov32), 32'd1);
    check({name, "_crc"}, crc32, exp);
    for (int c = 0; c < hold; c++) begin
      v32 = 1'b1; d32 = $urandom; k32 = 4'($urandom); l32 = 1'($urandom);
      @(posedge clk); #1;
      check({name, "_hold_valid"}, 32'(ov32), 32'd1);
      check({name, "_hold_crc"}, crc32, exp);
      check({name, "_hold_ready"}, 32'(rdy32), 32'd0);
    end
    v32 = 1'b0; ordy32 = 1'b1;
    @(posedge clk); #1;
    check({name, "_release"}, 32'(ov32), 32'd0);
  endtask

  typedef struct {
    logic [15:0] data;
    logic [1:0]  keep;
    logic [31:0] exp;
  } vec16_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bq_t s9, s4, q, qb;
    vec16_t tab16 [6];
    logic [31:0] f;
    int p;

    build_tab();
    s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    s4 = '{8'h31, 8'h32, 8'h33, 8'h34};

    tab16[0] = '{16'h0000, 2'b01, 32'hD202EF8D};
    tab16[1] = '{16'h0000, 2'b00, 32'h00000000};
    tab16[2] = '{16'h0061, 2'b01, 32'hE8B7BE43};
    tab16[3] = '{16'hFF61, 2'b01, 32'hE8B7BE43};
    tab16[4] = '{16'h0061, 2'b10, 32'h00000000};
    tab16[5] = '{16'h6261, 2'b11, ref_fcs('{8'h61, 8'h62})};

    rst_n = 1'b0; clr = 1'b0;
    v8 = 0; d8 = 0; k8 = 0; l8 = 0; ordy8 = 1;
    v16 = 0; d16 = 0; k16 = 0; l16 = 0; ordy16 = 1;
    v32 = 0; d32 = 0; k32 = 0; l32 = 0; ordy32 = 1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(rdy32), 32'd1);
    check("rst_out_valid", 32'(ov32), 32'd0);
    check("rst_out_crc", crc32, 32'd0);
    check("rst_out_ok", 32'(ok8), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Byte-wide reference string; also one-cycle out_valid.
    frame8(s9, 32'hCBF43926, 1'b0, "w8_check_string");

    // 32-bit, keep=0001 on the last beat, back-to-back twice.
    frame32(s9, 32'hCBF43926, 1'b0, 0, "w32_frame_a");
    frame32(s9, 32'hCBF43926, 1'b0, 0, "w32_frame_b");
    frame32('{}, 32'h00000000, 1'b0, 0, "w32_empty");

    // Check mode: string plus its FCS, then the same with one bit flipped.
    q = s9;
    q.push_back(8'h26); q.push_back(8'h39); q.push_back(8'hF4); q.push_back(8'hCB);
    frame8(q, 32'h2144DF1C, 1'b1, "chk_good");
    q[3] = q[3] ^ 8'h10;
    frame8(q, ref_fcs(q), 1'b0, "chk_bad");

    // 16-bit single-beat table.
    foreach (tab16[i]) begin
      beat16(tab16[i].data, tab16[i].keep, 1'b1);
      check($sformatf("w16_vec%0d_valid", i), 32'(ov16), 32'd1);
      check($sformatf("w16_vec%0d_crc", i), crc16, tab16[i].exp);
      @(posedge clk); #1;
      check($sformatf("w16_vec%0d_release", i), 32'(ov16), 32'd0);
    end
    for (int b = 0; b < 5; b++) begin
      beat16({(b < 4) ? s9[2*b+1] : 8'hEE, s9[2*b]}, (b < 4) ? 2'b11 : 2'b01, b == 4);
    end
    check("w16_string_crc", crc16, 32'hCBF43926);

    // Output back-pressure: 5 stalled cycles with beats offered.
    frame32(s9, 32'hCBF43926, 1'b0, 5, "w32_stall");
    frame32(s9, 32'hCBF43926, 1'b0, 0, "w32_after_stall");

    // Reset mid-frame, then clr mid-frame.
    foreach (s4[i]) beat8(s4[i], 1'b1, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_reset_no_output", 32'(ov8), 32'd0);
    frame8(s9, 32'hCBF43926, 1'b0, "after_reset");
    foreach (s4[i]) beat8(s4[i], 1'b1, 1'b0);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("mid_clr_no_output", 32'(ov8), 32'd0);
    frame8(s9, 32'hCBF43926, 1'b0, "after_clr");

    // Randomised 32-bit frames with gaps, junk enables and back-pressure.
    for (int t = 0; t < 25; t++) begin
      q = {};
      repeat ($urandom_range(0, 19)) q.push_back(8'($urandom));
      frame32(q, ref_fcs(q), 1'b1, $urandom_range(0, 2), $sformatf("rnd32_%0d", t));
    end

    // Randomised check-mode frames: good FCS, then one bit corrupted.
    for (int t = 0; t < 8; t++) begin
      q = {};
      repeat ($urandom_range(1, 12)) q.push_back(8'($urandom));
      f = ref_fcs(q);
      for (int j = 0; j < 4; j++) q.push_back(f[8*j +: 8]);
      frame8(q, 32'h2144DF1C, 1'b1, $sformatf("rnd_chk_good_%0d", t));
      qb = q;
      p = $urandom_range(0, qb.size() - 1);
      qb[p] = qb[p] ^ (8'h01 << $urandom_range(0, 7));
      frame8(qb, ref_fcs(qb), ref_fcs(qb) == 32'h2144DF1C, $sformatf("rnd_chk_bad_%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
